// File: rtl/mips_mdu_if.sv
// Controller <-> multiply/divide unit bundle: issue, MTHI/MTLO writes, HI/LO readback.
// Latency: none, wires only.
// Backpressure: the controller holds off issue while busy; there is no queuing.
interface mips_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Controller side: issues operations and MTHI/MTLO, reads HI/LO
    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mips_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO, with MTHI/MTLO writes.
// Latency: WIDTH+1 cycles from the accepting edge to done, independent of operands and op.
// Backpressure: busy high while in flight; start and HI/LO writes are dropped while busy.
module mips_mdu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mips_mdu_if.slave mdu
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Per-operation context captured on the accepting edge
    typedef struct packed {
        logic is_div;   // divide (1) or multiply (0)
        logic neg_lo;   // negate product / quotient
        logic neg_hi;   // negate remainder (sign of dividend)
        logic dz;       // divisor was zero
    } ctx_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;      // multiply: {upper, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    ctx_t               ctx_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;

    logic               accept, step, finish, wr_hi, wr_lo;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    ctx_t               ctx_d;
    logic [WIDTH:0]     mul_sum, div_dif;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_step, prod;
    logic [WIDTH-1:0]   quo, rem, hi_fix, lo_fix;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: IDLE -> CALC on start, WIDTH iterations, one fix-up cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mdu.start) state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath decode: capture values, one shift-add or shift-subtract step, sign fix-up
    always_comb begin
        accept = (state_q == S_IDLE) && mdu.start;
        step   = (state_q == S_CALC);
        finish = (state_q == S_FIX);
        wr_hi  = (state_q == S_IDLE) && !mdu.start && mdu.hi_we;
        wr_lo  = (state_q == S_IDLE) && !mdu.start && mdu.lo_we;

        // op[0] selects signed; magnitudes are taken only for signed ops
        a_neg = mdu.op[0] & mdu.a[WIDTH-1];
        b_neg = mdu.op[0] & mdu.b[WIDTH-1];
        mag_a = a_neg ? -mdu.a : mdu.a;
        mag_b = b_neg ? -mdu.b : mdu.b;

        ctx_d        = '0;
        ctx_d.is_div = mdu.op[1];
        ctx_d.neg_lo = a_neg ^ b_neg;
        ctx_d.neg_hi = a_neg;
        ctx_d.dz     = mdu.op[1] && (mdu.b == '0);

        // Radix-2 shift-add: add multiplicand into the upper half when the low bit is set, then shift right
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: shift next dividend bit into the remainder and try subtracting the divisor
        div_dif = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        div_nxt = div_dif[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        acc_step = ctx_q.is_div ? div_nxt : mul_nxt;

        prod = ctx_q.neg_lo ? -acc_q : acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        hi_fix = prod[2*WIDTH-1:WIDTH];
        lo_fix = prod[WIDTH-1:0];
        if (ctx_q.is_div) begin
            // Divide by zero leaves the raw dividend in the remainder; quotient is forced to all ones
            lo_fix = ctx_q.dz ? '1 : (ctx_q.neg_lo ? -quo : quo);
            hi_fix = ctx_q.neg_hi ? -rem : rem;
        end
    end

    // Iteration state: operand capture on accept, one step per CALC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            ctx_q  <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            acc_q  <= {{WIDTH{1'b0}}, (mdu.op[1] ? mag_a : mag_b)};
            opnd_q <= mdu.op[1] ? mag_b : mag_a;
            ctx_q  <= ctx_d;
        end else if (step) begin
            cnt_q  <= cnt_q + CW'(1);
            acc_q  <= acc_step;
        end
    end

    // Architectural HI/LO, done pulse and divide-by-zero flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                dz_q <= 1'b0;
            end else if (finish) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
                dz_q <= ctx_q.dz;
            end else begin
                if (wr_hi) hi_q <= mdu.wdata;
                if (wr_lo) lo_q <= mdu.wdata;
            end
        end
    end

    assign mdu.busy     = (state_q != S_IDLE);
    assign mdu.done     = done_q;
    assign mdu.div_zero = dz_q;
    assign mdu.hi       = hi_q;
    assign mdu.lo       = lo_q;
endmodule

// File: tb/tb_mips_mdu.sv
// Bench for mips_mdu: directed cases plus random ops checked against an arithmetic model.
// Latency: expects done WIDTH+1 cycles after each accepting edge.
// Backpressure: issues only when busy is low; pokes start/MTHI/MTLO while busy to see them dropped.
module tb_mips_mdu;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          issued = 0;
    logic [31:0] arch_hi, arch_lo;
    exp_t        sb_q[$];

    mips_mdu_if #(.WIDTH(W)) m ();
    mips_mdu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .mdu(m));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operands, truncating division
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        e.dz = 1'b0;
        e.acc_cyc = 0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'd0: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else if (op == 2'd2) begin
                    e.lo = a / b; e.hi = a % b;
                end else begin
                    e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (m.busy && n < 100) begin
            tick();
            n++;
        end
        if (m.busy) chk("idle_timeout", m.busy, 0);
    endtask

    // Issue one op; expected result goes into the scoreboard stamped with the accepting edge
    task automatic issue(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        exp_t e;
        wait_idle();
        m.start = 1'b1; m.op = op_i; m.a = a_i; m.b = b_i;
        tick();
        m.start = 1'b0; m.op = 2'($urandom); m.a = $urandom; m.b = $urandom;
        e = model(op_i, a_i, b_i);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        issued++;
    endtask

    // Monitor: every done pulse pops one expectation and checks result, flag and latency
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && m.done) begin
                done_cnt++;
                chk("done_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("res_hi", m.hi, e.hi);
                    chk("res_lo", m.lo, e.lo);
                    chk("res_div_zero", m.div_zero, e.dz);
                    chk("latency", cyc - e.acc_cyc, LAT);
                    arch_hi = e.hi;
                    arch_lo = e.lo;
                end
            end
        end
    endtask

    initial begin
        int          n;
        logic [1:0]  rop;
        logic [31:0] ra, rb, wv;

        m.start = 1'b0; m.op = 2'd0; m.a = '0; m.b = '0;
        m.hi_we = 1'b0; m.lo_we = 1'b0; m.wdata = '0;
        arch_hi = '0; arch_lo = '0;
        rst = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", m.busy, 0);
        chk("rst_done", m.done, 0);
        chk("rst_div_zero", m.div_zero, 0);
        chk("rst_hi", m.hi, 0);
        chk("rst_lo", m.lo, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // MULTU all-ones, busy for exactly LAT cycles
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (m.busy && n < 100) begin
            n++;
            tick();
        end
        chk("busy_cycles", n, LAT);
        chk("done_with_busy_low", m.done, 1);

        // MULT -3*5 then DIV -7/2 issued in the done cycle
        issue(2'd1, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        chk("b2b_in_done_cycle", m.done, 1);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2);

        // Edge divides and div_zero lifetime
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd2, 32'd5, 32'd0);
        wait_idle();
        chk("dz_set", m.div_zero, 1);
        issue(2'd0, 32'd3, 32'd4);
        chk("dz_cleared", m.div_zero, 0);

        // Start and MTHI while busy are ignored
        issue(2'd0, 32'd2, 32'd3);
        repeat (9) tick();
        m.start = 1'b1; m.a = 32'd9; m.b = 32'd9; m.hi_we = 1'b1; m.wdata = 32'h1234;
        tick();
        m.start = 1'b0; m.hi_we = 1'b0;
        chk("busy_mthi_ignored", m.hi, arch_hi);
        chk("busy_lo_held", m.lo, arch_lo);

        // MTHI / MTLO in idle
        wait_idle();
        m.hi_we = 1'b1; m.wdata = 32'hAAAA_0000;
        tick();
        m.hi_we = 1'b0;
        arch_hi = 32'hAAAA_0000;
        chk("mthi", m.hi, arch_hi);
        m.lo_we = 1'b1; m.wdata = 32'h0000_5555;
        tick();
        m.lo_we = 1'b0;
        arch_lo = 32'h0000_5555;
        chk("mtlo", m.lo, arch_lo);
        chk("mtlo_keeps_hi", m.hi, arch_hi);

        // Same-edge start and MTLO: the write is dropped
        m.lo_we = 1'b1; m.wdata = 32'hDEAD_BEEF;
        issue(2'd1, 32'd100, 32'hFFFF_FFF6);
        m.lo_we = 1'b0;
        chk("start_drops_mtlo", m.lo, arch_lo);

        // Reset mid-operation
        issue(2'd1, 32'd12345, 32'hFFFF_FFB3);
        repeat (14) tick();
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", m.busy, 0);
        chk("midrst_done", m.done, 0);
        chk("midrst_hi", m.hi, 0);
        chk("midrst_lo", m.lo, 0);
        issued = issued - sb_q.size();
        sb_q.delete();
        arch_hi = '0; arch_lo = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        issue(2'd0, 32'd7, 32'd6);

        // Random ops with idle writes and busy-time pokes
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                wv = $urandom;
                m.wdata = wv;
                if ($urandom_range(0, 1) == 1) begin
                    m.hi_we = 1'b1;
                    tick();
                    m.hi_we = 1'b0;
                    arch_hi = wv;
                    chk("rnd_mthi", m.hi, arch_hi);
                end else begin
                    m.lo_we = 1'b1;
                    tick();
                    m.lo_we = 1'b0;
                    arch_lo = wv;
                    chk("rnd_mtlo", m.lo, arch_lo);
                end
            end
            issue(rop, ra, rb);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 20)) tick();
                m.start = 1'b1; m.hi_we = 1'b1; m.lo_we = 1'b1; m.wdata = $urandom;
                tick();
                m.start = 1'b0; m.hi_we = 1'b0; m.lo_we = 1'b0;
                chk("rnd_busy_hi_held", m.hi, arch_hi);
                chk("rnd_busy_lo_held", m.lo, arch_lo);
            end
        end

        wait_idle();
        repeat (3) tick();
        chk("all_results_seen", sb_q.size(), 0);
        chk("done_count", done_cnt, issued);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_mdu.md
# mips_mdu

Iterative multiply/divide unit for the MIPS datapath: executes MULT, MULTU, DIV and DIVU over a parametrised operand width and holds the results in architectural HI/LO registers, with MTHI/MTLO write ports. It sits beside the single-cycle ALU. The controller issues an operation with `start`, stalls on `busy`, and reads HI/LO (MFHI/MFLO) once `done` has pulsed.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 2.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `start` in 1: request a new operation; accepted only in IDLE.
- `op` in 2: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in WIDTH: rs operand (multiplicand or dividend).
- `b` in WIDTH: rt operand (multiplier or divisor).
- `hi_we` in 1: MTHI strobe.
- `lo_we` in 1: MTLO strobe.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO hold a new result.
- `div_zero` out 1: the last accepted operation was a divide by zero.
- `hi` out WIDTH: HI register. Holds the upper product or the remainder.
- `lo` out WIDTH: LO register. Holds the lower product or the quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1:
  - Capture `op`.
  - Capture |a| and |b|; the magnitude is taken only for signed ops.
  - Capture the result signs.
  - Clear the iteration counter and `div_zero`; go to CALC.
- CALC: exactly WIDTH cycles.
  - Multiply: radix-2 shift-add on a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract on a WIDTH remainder/quotient pair.
  - Unsigned arithmetic on magnitudes.
  - After the counter reaches WIDTH−1, go to FIX.
- FIX: one cycle.
  - Apply sign correction and write `hi`/`lo`; pulse `done`; return to IDLE.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). This gives truncation toward zero.
- Divide by zero (b = 0, DIV or DIVU):
  - Run the normal latency.
  - Result: `lo` = all ones, `hi` = a (raw operand); `div_zero` = 1.
  - `div_zero` holds until the next accepted `start` or reset.
- Signed overflow (DIV, most-negative ÷ −1): `lo` = most-negative, `hi` = 0. This falls out of magnitude arithmetic with WIDTH-bit truncation.
- Operands are sampled only on the accepting edge. Changes to `a`/`b`/`op` while `busy` have no effect.
- `start` while `busy`: ignored. No queuing, no error.
- `hi_we`/`lo_we` in IDLE: load `wdata` at the edge.
- `hi_we`/`lo_we` while `busy`: ignored.
- Same edge in IDLE with both `start` and a write strobe: the `start` is accepted and the write is dropped.
- `hi`/`lo` change only in FIX, on MTHI/MTLO, or on reset. Intermediate values are never visible.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.
  - Counter and accumulators cleared.
- Reset asserted mid-operation aborts immediately. No `done` is produced and HI/LO read 0.
- `start` accepted at edge 0:
  - `busy`=1 from edge 0 through edge WIDTH+1.
  - CALC occupies edges 1..WIDTH; FIX is at edge WIDTH+1.
- At edge WIDTH+1: `hi`/`lo` updated; `done`=1 for exactly one cycle; `busy`=0.
- Latency is WIDTH+1 cycles, fixed and independent of operand values and op. WIDTH=32 gives 33.
- `done` and `busy`=0 are concurrent. A new `start` in the `done` cycle is accepted at that cycle's closing edge, giving back-to-back issue with no gap.
- `div_zero` becomes valid with `done` and is cleared at the next accepting edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULTU: a = b = 0xFFFFFFFF, WIDTH=32 → `done` exactly 33 cycles after the `start` edge; `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for 33 cycles.
- MULT −3 × 5, then back-to-back DIV −7 ÷ 2 issued in the `done` cycle:
  - First result: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - Second result: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, with `done` 33 cycles later.
- Edge divides:
  - DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
  - DIVU 5 ÷ 0 → `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1.
  - The next `start` clears `div_zero`.
- Busy-time inputs, during a MULTU 2 × 3:
  - At cycle 10, pulse `start` with new operands and `hi_we` with `wdata`=0x1234 → both ignored.
  - Final `hi`=0, `lo`=6, with a single `done`.
- MTHI/MTLO in IDLE:
  - `hi_we` with `wdata`=0xAAAA0000 and `lo_we` with `wdata`=0x5555 on separate edges → `hi`/`lo` load those values.
  - Same-edge `start` + `lo_we` → the write is dropped and the operation completes normally.
- Reset mid-op: drive `rst` low at cycle 15 of a MULT → `busy`, `done`, `hi`, `lo` go to 0 asynchronously. After release, a new MULTU 7 × 6 gives `lo`=42 after 33 cycles.
